// File: rtl/alu_multicycle.sv
// alu_multicycle: sequential slice-serial ALU with a valid/ready handshake.
// An operation is processed SLICE bits per clock, least-significant slice
// first, with the inter-slice carry held in carry_reg. The result and flags
// are held in DONE until the consumer accepts them.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NOR   = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_SLT   = 3'b110;
    localparam logic [2:0] OP_PASSA = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [2:0]        op_reg;
    logic              carry_reg;
    logic [IDXW-1:0]   idx_reg;
    logic [WIDTH-1:0]  result_reg;
    logic              cout_reg;
    logic              overflow_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;

    // Slice views of the latched operands, indexed by slice number.
    logic [SLICE-1:0]  a_sl_arr [NSLICE];
    logic [SLICE-1:0]  b_sl_arr [NSLICE];

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi = gi + 1) begin : g_slices
            assign a_sl_arr[gi] = a_reg[gi*SLICE +: SLICE];
            assign b_sl_arr[gi] = b_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  b_sl;
    logic [SLICE-1:0]  b_eff;
    logic [SLICE:0]    sum_full;
    logic              is_sub;
    logic              is_arith;
    logic              carry_out;
    logic              carry_msb;
    logic              slice_ovf;
    logic              slt_less;
    logic [SLICE-1:0]  slice_res;

    // Select the current slice and compute its result, carry and flag terms.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_reg == IDXW'(i)) begin
                a_sl = a_sl_arr[i];
                b_sl = b_sl_arr[i];
            end
        end

        is_sub   = (op_reg == OP_SUB) || (op_reg == OP_SLT);
        is_arith = (op_reg == OP_ADD) || is_sub;
        b_eff    = is_sub ? ~b_sl : b_sl;
        sum_full = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_reg};

        carry_out = sum_full[SLICE];
        // Carry into the slice MSB recovered from its sum bit and operand bits.
        carry_msb = sum_full[SLICE-1] ^ a_sl[SLICE-1] ^ b_eff[SLICE-1];
        slice_ovf = carry_msb ^ carry_out;
        slt_less  = sum_full[SLICE-1] ^ slice_ovf;

        case (op_reg)
            OP_AND:   slice_res = a_sl & b_sl;
            OP_OR:    slice_res = a_sl | b_sl;
            OP_XOR:   slice_res = a_sl ^ b_sl;
            OP_NOR:   slice_res = ~(a_sl | b_sl);
            OP_PASSA: slice_res = a_sl;
            default:  slice_res = sum_full[SLICE-1:0];
        endcase
    end

    // Control FSM plus operand, carry, result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= OP_AND;
            carry_reg     <= 1'b0;
            idx_reg       <= '0;
            result_reg    <= '0;
            cout_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        op_reg       <= op;
                        idx_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                        case (op)
                            OP_ADD:         carry_reg <= cin;
                            OP_SUB, OP_SLT: carry_reg <= 1'b1;
                            default:        carry_reg <= 1'b0;
                        endcase
                    end
                end
                RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (idx_reg == IDXW'(i)) begin
                            result_reg[i*SLICE +: SLICE] <= slice_res;
                        end
                    end
                    carry_reg <= carry_out;
                    idx_reg   <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        idx_reg       <= '0;
                        carry_reg     <= 1'b0;
                        cout_reg      <= is_arith ? carry_out : 1'b0;
                        overflow_reg  <= is_arith ? slice_ovf : 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                        if (op_reg == OP_SLT) begin
                            result_reg <= WIDTH'(slt_less);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign cout      = cout_reg;
    assign overflow  = overflow_reg;
    assign zero      = (result_reg == '0);
    assign negative  = result_reg[WIDTH-1];

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: default 32/8 instance plus 16/16 and
// 64/4 instances exercised against a full-width reference model.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // Default-parameter instance
    logic        in_valid, in_ready, out_valid, out_ready, cin;
    logic [31:0] a, b, result;
    logic [2:0]  op;
    logic        cout, overflow, zero, negative;

    alu_multicycle dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .cout(cout),
        .overflow(overflow), .zero(zero), .negative(negative)
    );

    // Sweep instances share operand drives, each has its own valid
    logic [63:0] sw_a, sw_b;
    logic [2:0]  sw_op;
    logic        sw_cin, sw_ordy, sw_iv16, sw_iv64;
    logic        s16_ir, s16_ov, s16_co, s16_of, s16_z, s16_n;
    logic [15:0] s16_res;
    logic        s64_ir, s64_ov, s64_co, s64_of, s64_z, s64_n;
    logic [63:0] s64_res;

    alu_multicycle #(.WIDTH(16), .SLICE(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(sw_iv16), .in_ready(s16_ir),
        .a(sw_a[15:0]), .b(sw_b[15:0]), .op(sw_op), .cin(sw_cin),
        .out_valid(s16_ov), .out_ready(sw_ordy), .result(s16_res),
        .cout(s16_co), .overflow(s16_of), .zero(s16_z), .negative(s16_n)
    );

    alu_multicycle #(.WIDTH(64), .SLICE(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(sw_iv64), .in_ready(s64_ir),
        .a(sw_a), .b(sw_b), .op(sw_op), .cin(sw_cin),
        .out_valid(s64_ov), .out_ready(sw_ordy), .result(s64_res),
        .cout(s64_co), .overflow(s64_of), .zero(s64_z), .negative(s64_n)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: {overflow, cout, result} at width w using full-width math.
    function automatic logic [65:0] model(input int w, input logic [63:0] aa, input logic [63:0] bb,
                                          input logic [2:0] oo, input logic cc);
        logic [63:0] mask, r, be, sa, sb;
        logic [64:0] full;
        logic        co, ov, c0;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        aa = aa & mask;
        bb = bb & mask;
        r = '0; co = 1'b0; ov = 1'b0;
        case (oo)
            3'b000: r = aa & bb;
            3'b001: r = aa | bb;
            3'b010: r = aa ^ bb;
            3'b011: r = ~(aa | bb) & mask;
            3'b111: r = aa;
            default: begin
                be   = (oo == 3'b100) ? bb : (~bb & mask);
                c0   = (oo == 3'b100) ? cc : 1'b1;
                full = {1'b0, aa} + {1'b0, be} + {64'd0, c0};
                r    = full[63:0] & mask;
                co   = full[w];
                ov   = (aa[w-1] == be[w-1]) && (r[w-1] != aa[w-1]);
                if (oo == 3'b110) begin
                    sa = aa | (aa[w-1] ? ~mask : 64'd0);
                    sb = bb | (bb[w-1] ? ~mask : 64'd0);
                    r  = ($signed(sa) < $signed(sb)) ? 64'd1 : 64'd0;
                end
            end
        endcase
        return {ov, co, r};
    endfunction

    // Issue one op on the default instance and wait (bounded) for out_valid.
    task automatic run_main(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                            input logic [2:0] oo, input logic cc);
        int n;
        a = aa; b = bb; op = oo; cin = cc; in_valid = 1'b1;
        chk({tag, " in_ready_before"}, 64'(in_ready), 64'd1);
        tick;
        in_valid = 1'b0;
        chk({tag, " in_ready_busy"}, 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd4);
        $display("txn %s a=%h b=%h op=%0d cin=%0b -> result=%h cout=%0b ovf=%0b z=%0b n=%0b",
                 tag, aa, bb, oo, cc, result, cout, overflow, zero, negative);
    endtask

    task automatic release_main(input string tag);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, " idle_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, " idle_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    // Issue one op on a sweep instance and compare against the model.
    task automatic run_sw(input int w, input logic [63:0] aa, input logic [63:0] bb,
                          input logic [2:0] oo, input logic cc);
        int          n;
        logic [65:0] e;
        logic [63:0] r_obs;
        logic        ov_obs, co_obs, of_obs, z_obs, n_obs;
        string       tag;
        tag = $sformatf("w%0d op%0d", w, oo);
        sw_a = aa; sw_b = bb; sw_op = oo; sw_cin = cc;
        if (w == 16) sw_iv16 = 1'b1; else sw_iv64 = 1'b1;
        tick;
        sw_iv16 = 1'b0; sw_iv64 = 1'b0;
        n = 0;
        ov_obs = (w == 16) ? s16_ov : s64_ov;
        while (!ov_obs && n < 40) begin
            tick;
            n++;
            ov_obs = (w == 16) ? s16_ov : s64_ov;
        end
        r_obs  = (w == 16) ? {48'd0, s16_res} : s64_res;
        co_obs = (w == 16) ? s16_co : s64_co;
        of_obs = (w == 16) ? s16_of : s64_of;
        z_obs  = (w == 16) ? s16_z : s64_z;
        n_obs  = (w == 16) ? s16_n : s64_n;
        e = model(w, aa, bb, oo, cc);
        chk({tag, " latency"}, 64'(n), (w == 16) ? 64'd1 : 64'd16);
        chk({tag, " result"}, r_obs, e[63:0]);
        chk({tag, " cout"}, 64'(co_obs), 64'(e[64]));
        chk({tag, " overflow"}, 64'(of_obs), 64'(e[65]));
        chk({tag, " zero"}, 64'(z_obs), 64'(e[63:0] == 64'd0));
        chk({tag, " negative"}, 64'(n_obs), 64'(e[w-1]));
        $display("txn %s a=%h b=%h cin=%0b -> result=%h cout=%0b ovf=%0b",
                 tag, aa, bb, cc, r_obs, co_obs, of_obs);
        sw_ordy = 1'b1;
        tick;
        sw_ordy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0;
        sw_a = '0; sw_b = '0; sw_op = '0; sw_cin = 1'b0; sw_ordy = 1'b0;
        sw_iv16 = 1'b0; sw_iv64 = 1'b0;

        // Reset then idle
        tick; tick;
        rst = 1'b0;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset zero", 64'(zero), 64'd1);
        chk("reset negative", 64'(negative), 64'd0);
        chk("reset cout", 64'(cout), 64'd0);
        repeat (5) tick;
        chk("idle out_valid", 64'(out_valid), 64'd0);

        // ADD carry chain through every slice
        run_main("add_chain", 32'hFFFF_FFFF, 32'h0000_0000, 3'b100, 1'b1);
        chk("add_chain result", 64'(result), 64'd0);
        chk("add_chain cout", 64'(cout), 64'd1);
        chk("add_chain zero", 64'(zero), 64'd1);
        chk("add_chain overflow", 64'(overflow), 64'd0);
        release_main("add_chain");

        // SUB with signed overflow
        run_main("sub_ovf", 32'h8000_0000, 32'h0000_0001, 3'b101, 1'b0);
        chk("sub_ovf result", 64'(result), 64'h7FFF_FFFF);
        chk("sub_ovf cout", 64'(cout), 64'd1);
        chk("sub_ovf overflow", 64'(overflow), 64'd1);
        chk("sub_ovf negative", 64'(negative), 64'd0);
        release_main("sub_ovf");

        // SLT -1 < 1
        run_main("slt", 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1'b0);
        chk("slt result", 64'(result), 64'd1);
        chk("slt cout", 64'(cout), 64'd1);
        chk("slt overflow", 64'(overflow), 64'd0);
        chk("slt zero", 64'(zero), 64'd0);
        release_main("slt");

        // Backpressure: result held while operands change
        run_main("bp_add", 32'd5, 32'd7, 3'b100, 1'b0);
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom;
            tick;
            chk($sformatf("bp_add stall%0d result", i), 64'(result), 64'd12);
            chk($sformatf("bp_add stall%0d out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp_add stall%0d in_ready", i), 64'(in_ready), 64'd0);
        end
        release_main("bp_add");

        // Reset on the second RUN cycle discards the op
        a = 32'h1234_5678; b = 32'h1111_1111; op = 3'b100; cin = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst result", 64'(result), 64'd0);
        chk("midrst zero", 64'(zero), 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk($sformatf("midrst quiet%0d out_valid", i), 64'(out_valid), 64'd0);
        end
        $display("txn midrst add discarded");

        run_main("xor", 32'hF0F0_F0F0, 32'hFFFF_0000, 3'b010, 1'b0);
        chk("xor result", 64'(result), 64'h0F0F_F0F0);
        chk("xor cout", 64'(cout), 64'd0);
        chk("xor overflow", 64'(overflow), 64'd0);
        chk("xor negative", 64'(negative), 64'd0);
        release_main("xor");

        // Parameter sweep: boundary vectors then random ops
        run_sw(16, 64'hFFFF, 64'h0, 3'b100, 1'b1);
        run_sw(16, 64'h8000, 64'h1, 3'b101, 1'b0);
        run_sw(16, 64'hFFFF, 64'h1, 3'b110, 1'b0);
        run_sw(64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'b100, 1'b1);
        run_sw(64, 64'h8000_0000_0000_0000, 64'h1, 3'b101, 1'b0);
        run_sw(64, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 3'b110, 1'b0);
        for (int i = 0; i < 16; i++) begin
            run_sw(16, {$urandom, $urandom}, {$urandom, $urandom}, 3'(i), 1'($urandom));
            run_sw(64, {$urandom, $urandom}, {$urandom, $urandom}, 3'(i), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, sequential successor to the 32-bit slice-chained ALU.
- Processes an N-bit operation as WIDTH/SLICE slices, one slice per clock, with the inter-slice carry held in a register instead of rippled combinationally.
- Uses valid/ready handshakes on input and output and adds SUB, SLT, overflow, zero and negative flags.
- Sits between operand registers and the writeback path wherever area matters more than latency.

Parameters:
- WIDTH, 32: operand/result width in bits. Must be a multiple of SLICE.
- SLICE, 8: bits processed per clock. 1 ≤ SLICE ≤ WIDTH.
- NSLICE, WIDTH/SLICE: derived (localparam), number of cycles per operation.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  operation code
- cin  in  1  carry-in, used by ADD only
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- cout  out  1  final carry-out
- overflow  out  1  signed overflow (ADD/SUB/SLT)
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]

Behaviour:
- Clock/reset: one clock domain (clk); reset is synchronous and active-high (rst).
- Op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NOR: bitwise; cout=0, overflow=0.
  - 100 ADD: a+b+cin.
  - 101 SUB: a+~b+1 (cin ignored); cout = no-borrow.
  - 110 SLT: signed compare; result = {0…0, less}, where less = sign(a−b) XOR overflow(a−b). cout/overflow report the internal subtraction.
  - 111 PASSA: result=a; cout=0, overflow=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b, op; initialise carry register (ADD: cin; SUB/SLT: 1; others: 0); slice index=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge computes slice [idx*SLICE +: SLICE] from the latched operands and the carry register, writes that slice of the result register, updates carry, and increments idx.
  - On the edge processing idx=NSLICE−1: capture cout, compute overflow from the top-slice carry-in/out, finalise SLT, go to DONE.
- Latency:
  - out_valid rises after exactly NSLICE rising edges following the accepting edge (defaults: 4).
  - WIDTH==SLICE gives latency 1.
- DONE:
  - out_valid=1.
  - result and all flags held stable until out_valid && out_ready; then go to IDLE.
  - in_ready stays 0 in DONE, so no same-cycle re-accept.
  - Peak throughput is one op per NSLICE+2 cycles.
- Output flags:
  - zero and negative are combinational from the result register.
  - All outputs change only on state transitions or slice writes.
- Input handling:
  - Inputs are ignored outside IDLE; changing a/b/op mid-operation has no effect.
  - in_valid held while busy is not lost: it is accepted on the first IDLE cycle.
- Reset (any state, including mid-RUN):
  - Next edge: state=IDLE, in_ready=1, out_valid=0, result=0, cout=0, overflow=0, carry/idx=0.
  - zero therefore reads 1 and negative reads 0 after reset.
  - A partially computed operation is discarded with no output.
- Arithmetic:
  - Modulo 2^WIDTH; no saturation.
  - overflow = carry into MSB XOR carry out of MSB.

Test Plan:
- Reset then idle: rst high 2 cycles → in_ready=1, out_valid=0, result=0, zero=1. Hold out_ready=0 with no input → out_valid stays 0.
- ADD carry chain: a=0xFFFFFFFF, b=0x00000000, cin=1, op=100 → out_valid exactly 4 edges after accept; result=0, cout=1, zero=1, overflow=0.
- SUB/overflow: a=0x80000000, b=1, op=101 → result=0x7FFFFFFF, cout=1, overflow=1, negative=0. Then SLT a=0xFFFFFFFF(−1), b=1 → result=1.
- Backpressure: complete ADD 5+7 with out_ready=0 for 10 cycles → result=12 held, in_ready=0; a and b toggled during the stall have no effect. Raising out_ready returns the block to IDLE on the next edge.
- Reset mid-operation: assert rst on the 2nd RUN cycle of an ADD → next edge IDLE, out_valid never asserts. A following XOR 0xF0F0F0F0^0xFFFF0000 yields 0x0F0FF0F0.
- Parameter sweep: WIDTH=16/SLICE=16 and WIDTH=64/SLICE=4 with random ops against a reference model → latency 1 and 16 respectively; all results and flags match.
